// File: rtl/dram_stream_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dram_stream_arbiter_pkg
// Shared definitions for the DRAM read-stream arbiter:
//   - default PE count and per-request beat-count width
//   - arb_state_e : controller states (IDLE -> STREAM -> DONE -> IDLE)
//   - next_pe()   : round-robin successor of a PE index, wrapping at num_pe
// -----------------------------------------------------------------------------
package dram_stream_arbiter_pkg;

  localparam int DSA_NUM_PE = 4;
  localparam int DSA_BEAT_W = 12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } arb_state_e;

  // Successor of id in a ring of num_pe requesters. Works for any num_pe,
  // not only powers of two.
  function automatic int unsigned next_pe(input int unsigned id,
                                          input int unsigned num_pe);
    return (id + 1 >= num_pe) ? 0 : id + 1;
  endfunction

endpackage

// File: rtl/dram_stream_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// dram_stream_arbiter_rr_arbiter
// Combinational round-robin pick: the first set bit of req_i at or after
// ptr_i, wrapping around to index 0.
// Ports:
//   req_i     in  NUM_PE   request vector
//   ptr_i     in  PE_ID_W  highest-priority index this cycle
//   onehot_o  out NUM_PE   one-hot winner (all zero when nothing requests)
//   idx_o     out PE_ID_W  binary index of the winner (0 when nothing requests)
//   found_o   out 1        at least one request was present
// -----------------------------------------------------------------------------
module dram_stream_arbiter_rr_arbiter #(
  parameter int NUM_PE  = 4,
  parameter int PE_ID_W = $clog2(NUM_PE)
) (
  input  logic [NUM_PE-1:0]  req_i,
  input  logic [PE_ID_W-1:0] ptr_i,
  output logic [NUM_PE-1:0]  onehot_o,
  output logic [PE_ID_W-1:0] idx_o,
  output logic               found_o
);

  // The search is split in two passes: indices from ptr_i upward first, then
  // the wrapped part below ptr_i. This avoids modulo arithmetic on the index.
  // NOTE: every output gets a default before the loops; without it, the
  // paths where no request matches would leave them unassigned and infer latches.
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    found_o  = 1'b0;
    for (int i = 0; i < NUM_PE; i++) begin
      if (!found_o && req_i[i] && (i >= int'(ptr_i))) begin
        found_o     = 1'b1;
        onehot_o[i] = 1'b1;
        idx_o       = PE_ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_PE; i++) begin
      if (!found_o && req_i[i] && (i < int'(ptr_i))) begin
        found_o     = 1'b1;
        onehot_o[i] = 1'b1;
        idx_o       = PE_ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/dram_stream_arbiter.sv
// -----------------------------------------------------------------------------
// dram_stream_arbiter
// Shares the single DRAM read stream between NUM_PE PE controllers. A
// round-robin arbiter grants one PE at a time. The block counts delivered
// beats and then pulses that PE's input- or filter-finish line for one cycle.
// Ports:
//   clk                   in  1              system clock
//   rst                   in  1              async reset, active low
//   req_valid             in  NUM_PE         per-PE stream request, held until finish
//   req_is_filter         in  NUM_PE         1 = filter burst, 0 = input-activation burst
//   req_beats             in  NUM_PE*BEAT_W  per-PE burst length, sampled at grant
//   dram_beat_valid       in  1              DRAM delivered one beat this cycle
//   grant                 out NUM_PE         one-hot owner of the stream
//   dram_req_valid        out 1              stream active (STREAM state)
//   dram_req_is_filter    out 1              type of the granted stream
//   dram_req_pe_id        out PE_ID_W        index of the granted PE
//   beat_cnt              out BEAT_W         beats received in the current stream
//   stream_input_finish   out NUM_PE         1-cycle pulse: input burst complete
//   stream_filter_finish  out NUM_PE         1-cycle pulse: filter burst complete
//   busy                  out 1              controller not in IDLE
// -----------------------------------------------------------------------------
module dram_stream_arbiter
  import dram_stream_arbiter_pkg::*;
#(
  parameter int NUM_PE  = DSA_NUM_PE,
  parameter int BEAT_W  = DSA_BEAT_W,
  parameter int PE_ID_W = $clog2(NUM_PE)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_PE-1:0]        req_valid,
  input  logic [NUM_PE-1:0]        req_is_filter,
  input  logic [NUM_PE*BEAT_W-1:0] req_beats,
  input  logic                     dram_beat_valid,
  output logic [NUM_PE-1:0]        grant,
  output logic                     dram_req_valid,
  output logic                     dram_req_is_filter,
  output logic [PE_ID_W-1:0]       dram_req_pe_id,
  output logic [BEAT_W-1:0]        beat_cnt,
  output logic [NUM_PE-1:0]        stream_input_finish,
  output logic [NUM_PE-1:0]        stream_filter_finish,
  output logic                     busy
);

  typedef struct packed {
    logic              valid;
    logic              is_filter;
    logic [BEAT_W-1:0] beats;
  } stream_req_t;

  stream_req_t req_arr [NUM_PE];

  always_comb begin
    for (int i = 0; i < NUM_PE; i++) begin
      req_arr[i].valid     = req_valid[i];
      req_arr[i].is_filter = req_is_filter[i];
      req_arr[i].beats     = req_beats[i*BEAT_W +: BEAT_W];
    end
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  arb_state_e          state_q,     state_d;
  logic [PE_ID_W-1:0]  rr_ptr_q,    rr_ptr_d;
  logic [NUM_PE-1:0]   grant_q,     grant_d;
  logic [PE_ID_W-1:0]  pe_id_q,     pe_id_d;
  logic                is_filter_q, is_filter_d;
  logic [BEAT_W-1:0]   len_q,       len_d;
  logic [BEAT_W-1:0]   beat_cnt_q,  beat_cnt_d;

  // ---------------------------------------------------------------------------
  // Round-robin pick
  // ---------------------------------------------------------------------------
  logic [NUM_PE-1:0]  pick_onehot;
  logic [PE_ID_W-1:0] pick_idx;
  logic               pick_found;
  stream_req_t        pick_req;

  dram_stream_arbiter_rr_arbiter #(
    .NUM_PE  (NUM_PE),
    .PE_ID_W (PE_ID_W)
  ) u_rr (
    .req_i    (req_valid),
    .ptr_i    (rr_ptr_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .found_o  (pick_found)
  );

  assign pick_req = req_arr[pick_idx];

  // Priority for the next round starts just past the PE that was served,
  // whether its stream completed or was aborted.
  logic [PE_ID_W-1:0] rr_after_owner;
  assign rr_after_owner = PE_ID_W'(next_pe(32'(pe_id_q), NUM_PE));

  logic beat_hit;
  assign beat_hit = dram_req_valid && dram_beat_valid;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    pe_id_d     = pe_id_q;
    is_filter_d = is_filter_q;
    len_d       = len_q;
    beat_cnt_d  = beat_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d     = pick_onehot;
          pe_id_d     = pick_idx;
          is_filter_d = pick_req.is_filter;
          len_d       = pick_req.beats;
          beat_cnt_d  = '0;
          // A zero-length burst is complete as soon as it is granted.
          state_d     = (pick_req.beats == '0) ? DONE : STREAM;
        end
      end

      STREAM: begin
        // Losing the request wins over a beat in the same cycle: the
        // stream is abandoned without a finish pulse.
        if (!req_arr[pe_id_q].valid) begin
          state_d    = IDLE;
          grant_d    = '0;
          beat_cnt_d = '0;
          rr_ptr_d   = rr_after_owner;
        end else if (beat_hit && (beat_cnt_q != len_q)) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (beat_cnt_q + 1'b1 == len_q) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        state_d    = IDLE;
        grant_d    = '0;
        beat_cnt_d = '0;
        rr_ptr_d   = rr_after_owner;
      end

      default: begin
        state_d    = IDLE;
        grant_d    = '0;
        beat_cnt_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: state is written with non-blocking assignments so every register
  // samples the pre-edge value of every other one, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      pe_id_q     <= '0;
      is_filter_q <= 1'b0;
      len_q       <= '0;
      beat_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      pe_id_q     <= pe_id_d;
      is_filter_q <= is_filter_d;
      len_q       <= len_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all derived from registers, so reset clears them immediately.
  // ---------------------------------------------------------------------------
  assign grant                = grant_q;
  assign dram_req_valid       = (state_q == STREAM);
  assign dram_req_is_filter   = is_filter_q;
  assign dram_req_pe_id       = pe_id_q;
  assign beat_cnt             = beat_cnt_q;
  assign busy                 = (state_q != IDLE);
  assign stream_input_finish  = ((state_q == DONE) && !is_filter_q) ? grant_q : '0;
  assign stream_filter_finish = ((state_q == DONE) &&  is_filter_q) ? grant_q : '0;

endmodule

// File: tb/tb_dram_stream_arbiter.sv
module tb_dram_stream_arbiter;

  localparam int NUM_PE  = 4;
  localparam int BEAT_W  = 12;
  localparam int PE_ID_W = 2;

  logic                     clk;
  logic                     rst;
  logic [NUM_PE-1:0]        req_valid;
  logic [NUM_PE-1:0]        req_is_filter;
  logic [NUM_PE*BEAT_W-1:0] req_beats;
  logic                     dram_beat_valid;
  logic [NUM_PE-1:0]        grant;
  logic                     dram_req_valid;
  logic                     dram_req_is_filter;
  logic [PE_ID_W-1:0]       dram_req_pe_id;
  logic [BEAT_W-1:0]        beat_cnt;
  logic [NUM_PE-1:0]        stream_input_finish;
  logic [NUM_PE-1:0]        stream_filter_finish;
  logic                     busy;

  dram_stream_arbiter #(
    .NUM_PE  (NUM_PE),
    .BEAT_W  (BEAT_W),
    .PE_ID_W (PE_ID_W)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .req_valid            (req_valid),
    .req_is_filter        (req_is_filter),
    .req_beats            (req_beats),
    .dram_beat_valid      (dram_beat_valid),
    .grant                (grant),
    .dram_req_valid       (dram_req_valid),
    .dram_req_is_filter   (dram_req_is_filter),
    .dram_req_pe_id       (dram_req_pe_id),
    .beat_cnt             (beat_cnt),
    .stream_input_finish  (stream_input_finish),
    .stream_filter_finish (stream_filter_finish),
    .busy                 (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One table row: inputs applied before an edge, outputs expected after it.
  typedef struct {
    string             name;
    logic [3:0]        rv;
    logic [3:0]        rf;
    logic [11:0]       b3, b2, b1, b0;
    logic              bv;
    logic [3:0]        e_grant;
    logic              e_drv;
    logic [11:0]       e_cnt;
    logic [1:0]        e_id;
    logic              e_filt;
    logic [3:0]        e_ifin;
    logic [3:0]        e_ffin;
    logic              e_busy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string name, input logic [3:0] rv, input logic [3:0] rf,
                     input logic [11:0] b3, input logic [11:0] b2, input logic [11:0] b1,
                     input logic [11:0] b0, input logic bv,
                     input logic [3:0] e_grant, input logic e_drv, input logic [11:0] e_cnt,
                     input logic [1:0] e_id, input logic e_filt, input logic [3:0] e_ifin,
                     input logic [3:0] e_ffin, input logic e_busy);
    vec_t v;
    v.name = name; v.rv = rv; v.rf = rf;
    v.b3 = b3; v.b2 = b2; v.b1 = b1; v.b0 = b0; v.bv = bv;
    v.e_grant = e_grant; v.e_drv = e_drv; v.e_cnt = e_cnt; v.e_id = e_id;
    v.e_filt = e_filt; v.e_ifin = e_ifin; v.e_ffin = e_ffin; v.e_busy = e_busy;
    vecs.push_back(v);
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    req_valid       = v.rv;
    req_is_filter   = v.rf;
    req_beats       = {v.b3, v.b2, v.b1, v.b0};
    dram_beat_valid = v.bv;
    @(posedge clk);
    #1;
    check({v.name, ".grant"},    grant,                v.e_grant);
    check({v.name, ".drv"},      dram_req_valid,       v.e_drv);
    check({v.name, ".beat_cnt"}, beat_cnt,             v.e_cnt);
    check({v.name, ".pe_id"},    dram_req_pe_id,       v.e_id);
    check({v.name, ".is_filt"},  dram_req_is_filter,   v.e_filt);
    check({v.name, ".in_fin"},   stream_input_finish,  v.e_ifin);
    check({v.name, ".fil_fin"},  stream_filter_finish, v.e_ffin);
    check({v.name, ".busy"},     busy,                 v.e_busy);
  endtask

  task automatic do_reset();
    rst             = 1'b0;
    req_valid       = '0;
    req_is_filter   = '0;
    req_beats       = '0;
    dram_beat_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic check_all_zero(input string name);
    check({name, ".grant"},    grant,                '0);
    check({name, ".drv"},      dram_req_valid,       '0);
    check({name, ".beat_cnt"}, beat_cnt,             '0);
    check({name, ".pe_id"},    dram_req_pe_id,       '0);
    check({name, ".is_filt"},  dram_req_is_filter,   '0);
    check({name, ".in_fin"},   stream_input_finish,  '0);
    check({name, ".fil_fin"},  stream_filter_finish, '0);
    check({name, ".busy"},     busy,                 '0);
  endtask

  initial begin
    // name            rv       rf       b3 b2 b1 b0 bv | grant   drv cnt id f  ifin     ffin     busy
    // PE2 input burst of 4 beats, one beat every cycle.
    add("s1_grant",    4'b0100, 4'b0000, 0, 4, 0, 0, 0,  4'b0100, 1, 0, 2, 0, 4'b0000, 4'b0000, 1);
    add("s1_b1",       4'b0100, 4'b0000, 0, 4, 0, 0, 1,  4'b0100, 1, 1, 2, 0, 4'b0000, 4'b0000, 1);
    add("s1_b2",       4'b0100, 4'b0000, 0, 4, 0, 0, 1,  4'b0100, 1, 2, 2, 0, 4'b0000, 4'b0000, 1);
    add("s1_b3",       4'b0100, 4'b0000, 0, 4, 0, 0, 1,  4'b0100, 1, 3, 2, 0, 4'b0000, 4'b0000, 1);
    add("s1_b4_done",  4'b0100, 4'b0000, 0, 4, 0, 0, 1,  4'b0100, 0, 4, 2, 0, 4'b0100, 4'b0000, 1);
    add("s1_idle",     4'b0000, 4'b0000, 0, 4, 0, 0, 0,  4'b0000, 0, 0, 2, 0, 4'b0000, 4'b0000, 0);
    // PE0 filter, 3 beats, beat_valid toggling; beats in IDLE/DONE ignored. rr_ptr=3 here.
    add("s3_grant",    4'b0001, 4'b0001, 0, 0, 0, 3, 1,  4'b0001, 1, 0, 0, 1, 4'b0000, 4'b0000, 1);
    add("s3_v1",       4'b0001, 4'b0001, 0, 0, 0, 3, 1,  4'b0001, 1, 1, 0, 1, 4'b0000, 4'b0000, 1);
    add("s3_n1",       4'b0001, 4'b0001, 0, 0, 0, 3, 0,  4'b0001, 1, 1, 0, 1, 4'b0000, 4'b0000, 1);
    add("s3_v2",       4'b0001, 4'b0001, 0, 0, 0, 3, 1,  4'b0001, 1, 2, 0, 1, 4'b0000, 4'b0000, 1);
    add("s3_n2",       4'b0001, 4'b0001, 0, 0, 0, 3, 0,  4'b0001, 1, 2, 0, 1, 4'b0000, 4'b0000, 1);
    add("s3_v3_done",  4'b0001, 4'b0001, 0, 0, 0, 3, 1,  4'b0001, 0, 3, 0, 1, 4'b0000, 4'b0001, 1);
    add("s3_idle",     4'b0000, 4'b0001, 0, 0, 0, 3, 1,  4'b0000, 0, 0, 0, 1, 4'b0000, 4'b0000, 0);
    // PE1 zero-length input request: straight to DONE, no dram_req_valid. rr_ptr=1 here.
    add("s4_zero_len", 4'b0010, 4'b0000, 0, 0, 0, 0, 1,  4'b0010, 0, 0, 1, 0, 4'b0010, 4'b0000, 1);
    add("s4_idle",     4'b0000, 4'b0000, 0, 0, 0, 0, 0,  4'b0000, 0, 0, 1, 0, 4'b0000, 4'b0000, 0);
    // rr_ptr=2 now: PE0 and PE2 both request, PE2 must win; PE0 follows two cycles after the pulse.
    add("rr_pe2",      4'b0101, 4'b0100, 0, 1, 0, 1, 0,  4'b0100, 1, 0, 2, 1, 4'b0000, 4'b0000, 1);
    add("rr_pe2_done", 4'b0101, 4'b0100, 0, 1, 0, 1, 1,  4'b0100, 0, 1, 2, 1, 4'b0000, 4'b0100, 1);
    add("rr_pe2_idle", 4'b0001, 4'b0100, 0, 1, 0, 1, 0,  4'b0000, 0, 0, 2, 1, 4'b0000, 4'b0000, 0);
    add("rr_pe0",      4'b0001, 4'b0100, 0, 1, 0, 1, 0,  4'b0001, 1, 0, 0, 0, 4'b0000, 4'b0000, 1);
    add("rr_pe0_done", 4'b0001, 4'b0100, 0, 1, 0, 1, 1,  4'b0001, 0, 1, 0, 0, 4'b0001, 4'b0000, 1);
    add("rr_pe0_idle", 4'b0000, 4'b0000, 0, 0, 0, 0, 0,  4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 0);

    // ---------------- Reset state ----------------
    rst             = 1'b0;
    req_valid       = '0;
    req_is_filter   = '0;
    req_beats       = '0;
    dram_beat_valid = 1'b0;
    #12;
    check_all_zero("reset");
    do_reset();

    // ---------------- Table ----------------
    foreach (vecs[i]) apply(vecs[i]);

    // ---------------- All four PEs request filters, 2 beats each ----------------
    begin
      int         order[$];
      int         fcnt[4];
      int         overlap;
      int         ipulse;
      logic [3:0] pulse_mask;
      overlap = 0;
      ipulse  = 0;
      foreach (fcnt[i]) fcnt[i] = 0;
      do_reset();
      @(negedge clk);
      req_valid       = 4'hF;
      req_is_filter   = 4'hF;
      req_beats       = {12'd2, 12'd2, 12'd2, 12'd2};
      dram_beat_valid = 1'b1;
      for (int c = 0; c < 60 && req_valid != 4'h0; c++) begin
        @(posedge clk);
        #1;
        if ($countones(grant) > 1) overlap++;
        if (stream_input_finish != 4'h0) ipulse++;
        pulse_mask = stream_filter_finish;
        for (int i = 0; i < 4; i++) begin
          if (pulse_mask[i]) begin
            fcnt[i]++;
            order.push_back(i);
          end
        end
        @(negedge clk);
        req_valid = req_valid & ~pulse_mask;
      end
      check("s2_all_served", req_valid, 4'h0);
      check("s2_pulse_count", order.size(), 4);
      for (int i = 0; i < order.size(); i++) check($sformatf("s2_order%0d", i), order[i], i);
      for (int i = 0; i < 4; i++) check($sformatf("s2_fcnt%0d", i), fcnt[i], 1);
      check("s2_overlap", overlap, 0);
      check("s2_no_input_pulse", ipulse, 0);
    end

    // ---------------- Abort: PE3 drops after 2 of 8 beats, PE0 pending ----------------
    do_reset();
    @(negedge clk);
    req_valid     = 4'b1000;
    req_is_filter = 4'b0000;
    req_beats     = {12'd8, 12'd0, 12'd0, 12'd0};
    @(posedge clk);
    #1;
    check("s5_grant3", grant, 4'b1000);
    @(negedge clk);
    dram_beat_valid = 1'b1;
    req_valid       = 4'b1001;
    req_beats       = {12'd8, 12'd0, 12'd0, 12'd1};
    @(posedge clk);
    #1;
    check("s5_cnt1", beat_cnt, 1);
    @(posedge clk);
    #1;
    check("s5_cnt2", beat_cnt, 2);
    @(negedge clk);
    req_valid       = 4'b0001;
    dram_beat_valid = 1'b0;
    @(posedge clk);
    #1;
    check("s5_abort_busy", busy, 1'b0);
    check("s5_abort_grant", grant, 4'b0000);
    check("s5_abort_in_fin", stream_input_finish, 4'b0000);
    check("s5_abort_fil_fin", stream_filter_finish, 4'b0000);
    @(posedge clk);
    #1;
    check("s5_pe0_grant", grant, 4'b0001);
    check("s5_pe0_id", dram_req_pe_id, 0);

    // ---------------- Reset mid-stream at beat 5 of 10 ----------------
    do_reset();
    @(negedge clk);
    req_valid       = 4'b0010;
    req_is_filter   = 4'b0000;
    req_beats       = {12'd0, 12'd0, 12'd10, 12'd0};
    dram_beat_valid = 1'b1;
    @(posedge clk);
    #1;
    check("s6_grant", grant, 4'b0010);
    repeat (5) @(posedge clk);
    #1;
    check("s6_cnt5", beat_cnt, 5);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("s6_async_rst");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("s6_regrant", grant, 4'b0010);
    check("s6_restart_cnt", beat_cnt, 0);
    // Changing the request after grant must not alter length or type.
    @(negedge clk);
    req_beats     = {12'd0, 12'd0, 12'd1, 12'd0};
    req_is_filter = 4'b0010;
    begin
      int waited;
      waited = 0;
      for (int c = 0; c < 30; c++) begin
        @(posedge clk);
        #1;
        if ((stream_input_finish | stream_filter_finish) != 4'h0) break;
        waited++;
      end
      check("s6_finish_latency", waited, 9);
      check("s6_in_fin", stream_input_finish, 4'b0010);
      check("s6_fil_fin", stream_filter_finish, 4'b0000);
      check("s6_cnt_len", beat_cnt, 10);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
